sonar_tof_array: RTL and testbench

//  N-channel sonar echo detector with a time-of-flight (TOF) measurement sequencer and a Wishbone-style register file.
//  Per channel: gain, abs, moving average, threshold compare, sticky hit, TOF capture.

---
 rtl/sonar_pkg.sv | 47 ++++
 rtl/sonar_echo_channel.sv | 59 +++++
 rtl/sonar_tof_array.sv | 197 +++++++++++++++++++
 tb/tb_sonar_tof_array.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared constants, state encoding and saturating helpers for the sonar TOF array.
package sonar_pkg;

    localparam int unsigned REG_CTRL    = 0;
    localparam int unsigned REG_STATUS  = 1;
    localparam int unsigned REG_BLANK   = 2;
    localparam int unsigned REG_TIMEOUT = 3;
    localparam int unsigned REG_CH_BASE = 16;

    localparam int unsigned CH_AMP    = 0;
    localparam int unsigned CH_THRESH = 1;
    localparam int unsigned CH_TOF    = 2;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_BYPASS = 2;

    localparam int unsigned STATUS_DONE    = 2;
    localparam int unsigned STATUS_HIT_LSB = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBlank  = 2'd1,
        StListen = 2'd2,
        StDone   = 2'd3
    } sonar_state_e;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v,
                                                 input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [31:0] abs_s(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/sonar_echo_channel.sv
// One echo channel: gain, magnitude, moving-average ring buffer and threshold compare.
module sonar_echo_channel
    import sonar_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         bypass,
    input  logic [W-1:0] x,
    input  logic [7:0]   amp,
    input  logic [W-1:0] thresh,
    output logic         cmp
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SW    = W + AVG_LOG2;

    logic [W-1:0]         hist_q [DEPTH];
    logic [AVG_LOG2-1:0]  ptr_q;
    logic [SW-1:0]        sum_q;
    logic [SW-1:0]        sum_d;
    logic signed [31:0]   prod;
    logic signed [31:0]   gain;
    logic signed [31:0]   mag;
    logic [W-1:0]         a;
    logic [W-1:0]         m;
    logic                 unused_mag;

    // The sum includes the sample being presented, so the compare sees it on the same strobe.
    always_comb begin
        prod  = $signed({{(32 - W){x[W-1]}}, x}) * $signed({24'd0, amp});
        gain  = sat_s(prod >>> 4, W);
        mag   = sat_s(abs_s(gain), W);
        a     = mag[W-1:0];
        sum_d = sum_q + SW'(a) - SW'(hist_q[ptr_q]);
        m     = bypass ? a : sum_d[SW-1:AVG_LOG2];
        cmp   = m > thresh;
    end

    assign unused_mag = ^mag[31:W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                hist_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
        end else if (ce) begin
            hist_q[ptr_q] <= a;
            ptr_q         <= ptr_q + 1'b1;
            sum_q         <= sum_d;
        end
    end

endmodule

// File: rtl/sonar_tof_array.sv
// N-channel sonar echo detector: register file, sample timer, measurement FSM and TOF capture.
module sonar_tof_array
    import sonar_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned W        = 16,
    parameter int unsigned TW       = 16,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    input  logic [W-1:0]      wbs_dat_i,
    input  logic              wbs_strb_i,
    output logic              wbs_ack_o,
    output logic [W-1:0]      wbs_dat_o,
    input  logic              ce_pcm,
    input  logic [N_CH*W-1:0] pcm_i,
    output logic [N_CH-1:0]   hit_o,
    output logic              busy_o,
    output logic              done_irq_o
);

    localparam logic [W-1:0] THRESH_RST = W'(16'h0400);

    sonar_state_e        state_q, state_d;
    logic [7:0]          amp_q    [N_CH];
    logic [W-1:0]        thresh_q [N_CH];
    logic [TW-1:0]       tof_q    [N_CH];
    logic [TW-1:0]       tof_d    [N_CH];
    logic [TW-1:0]       blank_q, timeout_q, timer_q, timer_d;
    logic [N_CH-1:0]     hit_q, hit_d, cmp;
    logic                bypass_q, done_q, done_d, irq_q, irq_d, ack_q;
    logic [W-1:0]        rdata_q, rdata_d;

    logic                wr_en, rd_en, ch_sel, start, abort;
    logic [ADDR_W-1:0]   ch_adr;
    logic [ADDR_W-3:0]   ch_idx;
    logic [1:0]          ch_off;

    always_comb begin
        wr_en  = wb_valid_i & wbs_strb_i;
        rd_en  = wb_valid_i & ~wbs_strb_i;
        ch_adr = wbs_adr_i - ADDR_W'(REG_CH_BASE);
        ch_idx = ch_adr[ADDR_W-1:2];
        ch_off = ch_adr[1:0];
        ch_sel = wbs_adr_i >= ADDR_W'(REG_CH_BASE);
        start  = wr_en && (wbs_adr_i == ADDR_W'(REG_CTRL)) && wbs_dat_i[CTRL_START];
        abort  = wr_en && (wbs_adr_i == ADDR_W'(REG_CTRL)) && wbs_dat_i[CTRL_ABORT];
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        sonar_echo_channel #(
            .W        (W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .ce     (ce_pcm),
            .bypass (bypass_q),
            .x      (pcm_i[k*W +: W]),
            .amp    (amp_q[k]),
            .thresh (thresh_q[k]),
            .cmp    (cmp[k])
        );
    end

    // Timer, hit and TOF next state; abort suppresses both start and sample updates.
    always_comb begin
        timer_d = timer_q;
        hit_d   = hit_q;
        tof_d   = tof_q;
        if (start && !abort) begin
            timer_d = '0;
            hit_d   = '0;
            for (int k = 0; k < int'(N_CH); k++) begin
                tof_d[k] = '0;
            end
        end else if (!abort && ce_pcm && (state_q == StBlank || state_q == StListen)) begin
            timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
            if (state_q == StListen) begin
                for (int k = 0; k < int'(N_CH); k++) begin
                    if (cmp[k] && !hit_q[k]) begin
                        hit_d[k] = 1'b1;
                        tof_d[k] = timer_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else if (start) begin
            state_d = StBlank;
        end else if (ce_pcm) begin
            unique case (state_q)
                StBlank:  if (timer_q == blank_q) state_d = StListen;
                StListen: if ((&hit_d) || (timer_q == timeout_q)) state_d = StDone;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        irq_d      = (state_d == StDone) && (state_q != StDone);
        done_d     = (start && !abort) ? 1'b0 : (done_q | irq_d);
        busy_o     = (state_q == StBlank) || (state_q == StListen);
        hit_o      = hit_q;
        done_irq_o = irq_q;
        wbs_ack_o  = ack_q;
        wbs_dat_o  = rdata_q;
    end

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (wbs_adr_i)
                ADDR_W'(REG_CTRL):    rdata_d[CTRL_BYPASS] = bypass_q;
                ADDR_W'(REG_STATUS): begin
                    rdata_d[1:0]                     = state_q;
                    rdata_d[STATUS_DONE]             = done_q;
                    rdata_d[STATUS_HIT_LSB +: N_CH]  = hit_q;
                end
                ADDR_W'(REG_BLANK):   rdata_d = W'(blank_q);
                ADDR_W'(REG_TIMEOUT): rdata_d = W'(timeout_q);
                default: begin
                    for (int k = 0; k < int'(N_CH); k++) begin
                        if (ch_sel && ch_idx == (ADDR_W-2)'(k)) begin
                            case (ch_off)
                                2'(CH_AMP):    rdata_d = W'(amp_q[k]);
                                2'(CH_THRESH): rdata_d = thresh_q[k];
                                2'(CH_TOF):    rdata_d = W'(tof_q[k]);
                                default:       rdata_d = '0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                amp_q[k]    <= '0;
                thresh_q[k] <= THRESH_RST;
                tof_q[k]    <= '0;
            end
            blank_q   <= '0;
            timeout_q <= '1;
            bypass_q  <= 1'b0;
            timer_q   <= '0;
            hit_q     <= '0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            timer_q <= timer_d;
            hit_q   <= hit_d;
            tof_q   <= tof_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            ack_q   <= wb_valid_i;
            rdata_q <= rdata_d;
            if (wr_en) begin
                case (wbs_adr_i)
                    ADDR_W'(REG_CTRL):    bypass_q  <= wbs_dat_i[CTRL_BYPASS];
                    ADDR_W'(REG_BLANK):   blank_q   <= wbs_dat_i[TW-1:0];
                    ADDR_W'(REG_TIMEOUT): timeout_q <= wbs_dat_i[TW-1:0];
                    default: begin
                        for (int k = 0; k < int'(N_CH); k++) begin
                            if (ch_sel && ch_idx == (ADDR_W-2)'(k)) begin
                                if (ch_off == 2'(CH_AMP))    amp_q[k]    <= wbs_dat_i[7:0];
                                if (ch_off == 2'(CH_THRESH)) thresh_q[k] <= wbs_dat_i;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sonar_tof_array.sv
// Randomised and directed bench for sonar_tof_array against a sample-level behavioural model.
module tb_sonar_tof_array;

    localparam int N_CH = 4;
    localparam int W    = 16;
    localparam int TW   = 16;
    localparam int AVGL = 3;
    localparam int AW   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid_i;
    logic [AW-1:0]     wbs_adr_i;
    logic [W-1:0]      wbs_dat_i;
    logic              wbs_strb_i;
    logic              wbs_ack_o;
    logic [W-1:0]      wbs_dat_o;
    logic              ce_pcm;
    logic [N_CH*W-1:0] pcm_i;
    logic [N_CH-1:0]   hit_o;
    logic              busy_o;
    logic              done_irq_o;

    always #5 clk = ~clk;

    sonar_tof_array #(
        .N_CH     (N_CH),
        .W        (W),
        .TW       (TW),
        .AVG_LOG2 (AVGL),
        .ADDR_W   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid_i (wb_valid_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_strb_i (wbs_strb_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ce_pcm     (ce_pcm),
        .pcm_i      (pcm_i),
        .hit_o      (hit_o),
        .busy_o     (busy_o),
        .done_irq_o (done_irq_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: 0 idle, 1 blank, 2 listen, 3 done.
    int m_state, m_timer, m_blank, m_timeout, m_bypass, m_done, m_irq;
    int m_amp [N_CH];
    int m_thr [N_CH];
    int m_tof [N_CH];
    bit m_hit [N_CH];
    int m_hist[N_CH][$];
    int xs    [N_CH];

    function automatic void m_reset();
        m_state = 0; m_timer = 0; m_blank = 0; m_timeout = 'hFFFF;
        m_bypass = 0; m_done = 0; m_irq = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_amp[k] = 0; m_thr[k] = 'h0400; m_tof[k] = 0; m_hit[k] = 0;
            m_hist[k].delete();
            for (int i = 0; i < (1 << AVGL); i++) m_hist[k].push_back(0);
        end
    endfunction

    function automatic int m_hitmask();
        int v = 0;
        for (int k = 0; k < N_CH; k++) if (m_hit[k]) v |= (1 << k);
        return v;
    endfunction

    function automatic void m_write(input int adr, input int dat);
        int idx, off;
        if (adr == 0) begin
            m_bypass = (dat >> 2) & 1;
            if (dat & 2) begin
                m_state = 0;
            end else if (dat & 1) begin
                m_state = 1; m_timer = 0; m_done = 0;
                for (int k = 0; k < N_CH; k++) begin m_hit[k] = 0; m_tof[k] = 0; end
            end
        end else if (adr == 2) begin
            m_blank = dat;
        end else if (adr == 3) begin
            m_timeout = dat;
        end else if (adr >= 16) begin
            idx = (adr - 16) / 4; off = (adr - 16) % 4;
            if (idx < N_CH && off == 0) m_amp[idx] = dat & 255;
            if (idx < N_CH && off == 1) m_thr[idx] = dat;
        end
    endfunction

    function automatic int m_read(input int adr);
        int idx, off;
        case (adr)
            0: return m_bypass << 2;
            1: return m_state | (m_done << 2) | (m_hitmask() << 4);
            2: return m_blank;
            3: return m_timeout;
            default: begin
                if (adr < 16) return 0;
                idx = (adr - 16) / 4; off = (adr - 16) % 4;
                if (idx >= N_CH) return 0;
                if (off == 0) return m_amp[idx];
                if (off == 1) return m_thr[idx];
                if (off == 2) return m_tof[idx];
                return 0;
            end
        endcase
    endfunction

    function automatic void m_sample();
        bit cmp [N_CH];
        int g, a, sum, st0;
        bit all_hit;
        m_irq = 0;
        st0 = m_state;
        for (int k = 0; k < N_CH; k++) begin
            g = (xs[k] * m_amp[k]) >>> 4;
            if (g > 32767) g = 32767;
            if (g < -32768) g = -32768;
            a = (g < 0) ? -g : g;
            if (a > 32767) a = 32767;
            m_hist[k].push_back(a);
            void'(m_hist[k].pop_front());
            sum = 0;
            foreach (m_hist[k][i]) sum += m_hist[k][i];
            cmp[k] = ((m_bypass != 0) ? a : sum / (1 << AVGL)) > m_thr[k];
        end
        if (st0 == 1) begin
            if (m_timer == m_blank) m_state = 2;
        end else if (st0 == 2) begin
            all_hit = 1;
            for (int k = 0; k < N_CH; k++) begin
                if (cmp[k] && !m_hit[k]) begin m_hit[k] = 1; m_tof[k] = m_timer; end
                all_hit &= m_hit[k];
            end
            if (all_hit || m_timer == m_timeout) begin m_state = 3; m_done = 1; m_irq = 1; end
        end
        if ((st0 == 1 || st0 == 2) && m_timer < 'hFFFF) m_timer++;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input int adr, input int dat);
        wb_valid_i = 1'b1; wbs_strb_i = 1'b1;
        wbs_adr_i = AW'(adr); wbs_dat_i = W'(dat);
        @(posedge clk); #1;
        wb_valid_i = 1'b0; wbs_strb_i = 1'b0;
        m_write(adr, dat);
        check("wr_ack", wbs_ack_o, 1);
    endtask

    task automatic bus_read(input int adr, output int v);
        wb_valid_i = 1'b1; wbs_strb_i = 1'b0; wbs_adr_i = AW'(adr);
        @(posedge clk); #1;
        wb_valid_i = 1'b0;
        check("rd_ack", wbs_ack_o, 1);
        v = int'(wbs_dat_o);
        @(posedge clk); #1;
        check("ack_len", wbs_ack_o, 0);
    endtask

    task automatic read_model(input int adr);
        int v, e;
        e = m_read(adr);
        bus_read(adr, v);
        check($sformatf("rd_%0d", adr), v, e);
    endtask

    task automatic do_sample(input string tag);
        for (int k = 0; k < N_CH; k++) pcm_i[k*W +: W] = W'(xs[k]);
        ce_pcm = 1'b1;
        @(posedge clk); #1;
        ce_pcm = 1'b0;
        m_sample();
        check({tag, "_hit"}, hit_o, m_hitmask());
        check({tag, "_busy"}, busy_o, (m_state == 1 || m_state == 2));
        check({tag, "_irq"}, done_irq_o, m_irq);
        @(posedge clk); #1;
        check({tag, "_irq_len"}, done_irq_o, 0);
    endtask

    task automatic set_x(input int v0, input int vr);
        xs[0] = v0;
        for (int k = 1; k < N_CH; k++) xs[k] = vr;
    endtask

    task automatic read_all();
        for (int a = 0; a < 4; a++) read_model(a);
        for (int a = 16; a < 16 + 4 * N_CH; a++) read_model(a);
    endtask

    int v;
    logic signed [15:0] rs;

    initial begin
        rst = 1'b1; wb_valid_i = 1'b0; wbs_strb_i = 1'b0; wbs_adr_i = '0; wbs_dat_i = '0;
        ce_pcm = 1'b0; pcm_i = '0;
        m_reset(); set_x(0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_hit", hit_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_irq", done_irq_o, 0);
        check("rst_ack", wbs_ack_o, 0);
        bus_read(17, v);  check("rst_thresh0", v, 'h0400);
        bus_read(3, v);   check("rst_timeout", v, 'hFFFF);
        bus_read(1, v);   check("rst_status", v, 0);
        bus_write(1, 'hFFFF); bus_write(40, 'h1234); bus_write(19, 'h55AA);
        read_all();
        read_model(40); read_model(63); read_model(5);

        // Constant 0x200 into ch0 with BLANK=2.
        bus_write(16, 16); bus_write(17, 'h01FF);
        for (int k = 1; k < N_CH; k++) bus_write(17 + 4 * k, 'hFFFF);
        bus_write(2, 2);
        set_x('h200, 0);
        for (int i = 0; i < 8; i++) do_sample("pre2");
        bus_write(0, 1);
        for (int i = 0; i < 3; i++) do_sample("blank2");
        bus_read(1, v); check("t2_listen", v & 3, 2);
        do_sample("listen2");
        check("t2_hit0", hit_o[0], 1);
        bus_read(18, v); check("t2_tof0", v, 3);
        bus_write(0, 2);

        // Most negative sample at full gain must clamp to a large positive magnitude.
        bus_write(16, 255); bus_write(17, 'h7FFE); bus_write(2, 0);
        set_x(-32768, 0);
        for (int i = 0; i < 8; i++) do_sample("pre3");
        bus_write(0, 1);
        do_sample("blank3");
        do_sample("listen3");
        check("t3_sat_hit", hit_o[0], 1);
        bus_write(0, 2);

        // Step response through the 8-deep average, then with bypass.
        bus_write(16, 16); bus_write(17, 'h03FF);
        set_x(0, 0);
        for (int i = 0; i < 8; i++) do_sample("pre4");
        bus_write(0, 1);
        do_sample("blank4");
        set_x('h800, 0);
        for (int i = 0; i < 4; i++) begin
            do_sample("step4");
            check($sformatf("t4_step%0d", i), hit_o[0], (i == 3));
        end
        bus_read(18, v); check("t4_tof0", v, 4);
        bus_write(0, 6);
        set_x(0, 0);
        for (int i = 0; i < 8; i++) do_sample("pre4b");
        bus_write(0, 5);
        do_sample("blank4b");
        set_x('h800, 0);
        do_sample("step4b");
        check("t4_bypass_hit", hit_o[0], 1);
        bus_write(0, 2);

        // Timeout with no echo.
        for (int k = 0; k < N_CH; k++) bus_write(17 + 4 * k, 'hFFFF);
        bus_write(3, 10);
        set_x(0, 0);
        bus_write(0, 1);
        for (int i = 0; i < 11; i++) do_sample("tmo5");
        bus_read(1, v); check("t5_status_tmo", v, 'h7);

        // All channels hit on sample 5.
        bus_write(3, 'hFFFF);
        for (int k = 0; k < N_CH; k++) begin bus_write(16 + 4 * k, 16); bus_write(17 + 4 * k, 'h3FF); end
        bus_write(0, 5);
        for (int i = 0; i < 4; i++) do_sample("all5");
        set_x('h800, 'h800);
        do_sample("all5hit");
        check("t5_all_irq_seen", m_irq, 1);
        bus_read(1, v); check("t5_status_all", v, 'hF7);
        for (int k = 0; k < N_CH; k++) read_model(18 + 4 * k);

        // Start and abort together: abort wins and hits are kept.
        bus_write(0, 7);
        bus_read(1, v); check("t6_both_state", v & 3, 0);
        check("t6_both_hits", hit_o, 'hF);

        // Abort mid-listen keeps hits.
        set_x(0, 0);
        bus_write(0, 5);
        do_sample("t6a");
        set_x('h800, 0);
        do_sample("t6b");
        bus_write(0, 2);
        check("t6_abort_hits", hit_o, 1);
        check("t6_abort_busy", busy_o, 0);
        read_model(1);

        // Randomised measurements.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N_CH; k++) begin
                bus_write(16 + 4 * k, $urandom_range(0, 255));
                bus_write(17 + 4 * k, $urandom_range(0, 'h1800));
            end
            bus_write(2, $urandom_range(0, 4));
            bus_write(3, $urandom_range(3, 30));
            bus_write(0, 1 | ($urandom_range(0, 1) << 2));
            for (int s = 0; s < 40; s++) begin
                for (int k = 0; k < N_CH; k++) begin
                    rs = 16'($urandom);
                    xs[k] = ($urandom_range(0, 3) == 0) ? int'(rs) : $urandom_range(0, 600) - 300;
                end
                do_sample("rnd");
                if ($urandom_range(0, 3) == 0) read_model($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) bus_write(17 + 4 * $urandom_range(0, N_CH - 1),
                                                         $urandom_range(0, 'h1000));
                if ($urandom_range(0, 39) == 0) bus_write(0, 2);
            end
            read_all();
        end

        // Reset in the middle of a measurement.
        bus_write(2, 0); bus_write(3, 'hFFFF);
        bus_write(0, 5);
        set_x('h800, 0);
        do_sample("prerst");
        do_sample("prerst");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        check("rst2_hit", hit_o, 0);
        check("rst2_busy", busy_o, 0);
        check("rst2_irq", done_irq_o, 0);
        check("rst2_ack", wbs_ack_o, 0);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
